// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that lets NREQ requesters share one uart_xmtr.
// Each winner gets one LOAD strobe, and the next grant waits until its frame has been sent.
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int WD_SIZE      = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WD_SIZE-1:0] data_i,
    output logic [NREQ-1:0]         ack_o,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    load_xmt_o,
    output logic [WD_SIZE-1:0]      bus_data_o,
    output logic                    busy_o
);

    localparam int FRAME_CYC = CLKS_PER_BIT * (WD_SIZE + 2);
    localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW        = $clog2(FRAME_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_ptr, w_ptr_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [WD_SIZE-1:0]  r_word, w_word_nxt;
    logic [NREQ-1:0]     w_ack_nxt, w_gnt_nxt;
    logic                w_load_nxt;
    logic [WD_SIZE-1:0]  w_bus_nxt;
    logic                w_found;
    logic [PW-1:0]       w_idx;
    logic [WD_SIZE-1:0]  w_slice;
    int                  w_j;

    // Search upward from r_ptr, wrapping at NREQ, for the first pending request.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            if (!w_found && req_i[w_j]) begin
                w_found = 1'b1;
                w_idx   = PW'(w_j);
            end
        end
        w_slice = data_i[int'(w_idx)*WD_SIZE +: WD_SIZE];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_ack_nxt   = '0;
        w_gnt_nxt   = gnt_o;
        w_load_nxt  = 1'b0;
        w_bus_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (en_i && w_found) begin
                    w_state_nxt = S_LOAD;
                    w_word_nxt  = w_slice;
                    w_ptr_nxt   = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + PW'(1);
                    w_ack_nxt   = NREQ'(1) << w_idx;
                    w_gnt_nxt   = NREQ'(1) << w_idx;
                    w_load_nxt  = 1'b1;
                    w_bus_nxt   = w_slice;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = CW'(FRAME_CYC - 1);
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // The outputs are registered from the next-state values, so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            ack_o      <= '0;
            gnt_o      <= '0;
            load_xmt_o <= 1'b0;
            bus_data_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_word     <= w_word_nxt;
            ack_o      <= w_ack_nxt;
            gnt_o      <= w_gnt_nxt;
            load_xmt_o <= w_load_nxt;
            bus_data_o <= w_bus_nxt;
            busy_o     <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with NREQ=4, WD_SIZE=8 and CLKS_PER_BIT=4 (40-cycle frames).
// Stimulus queues the expected grant; the monitor checks every load strobe against that queue.
module tb_uart_tx_sched;

    localparam int NREQ = 4;
    localparam int WD   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic [NREQ-1:0]  req_i;
    logic [NREQ*WD-1:0] data_i;
    logic [NREQ-1:0]  ack_o, gnt_o;
    logic             load_xmt_o;
    logic [WD-1:0]    bus_data_o;
    logic             busy_o;

    uart_tx_sched #(.NREQ(NREQ), .WD_SIZE(WD), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .req_i(req_i), .data_i(data_i),
        .ack_o(ack_o), .gnt_o(gnt_o), .load_xmt_o(load_xmt_o),
        .bus_data_o(bus_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   autodrop = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic expect_load(input int idx, input logic [7:0] d, input int c);
        exp_t e;
        e.idx = idx; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Monitor: every load strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (load_xmt_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_load", {24'h0, bus_data_o}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("load_data", {24'h0, bus_data_o}, {24'h0, e.data});
                    chk("load_ack",  {28'h0, ack_o}, 32'(1 << e.idx));
                    chk("load_gnt",  {28'h0, gnt_o}, 32'(1 << e.idx));
                    chk("load_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("ack_outside_load", {28'h0, ack_o}, 32'h0);
            end
        end
    end

    // Requester model: a requester drops its bit in the cycle it is acked.
    initial begin
        forever begin
            @(negedge clk);
            if (autodrop) req_i = req_i & ~ack_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n;
        rst = 1'b1; en_i = 1'b0; req_i = '0; data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {19'h0, ack_o, gnt_o, load_xmt_o, bus_data_o, busy_o}, 32'h0);
        step();
        rst = 1'b0;
        step(); step();

        // Every requester asks; grants follow 0,1,2,3 at 42-cycle spacing.
        autodrop = 1'b1;
        c = cyc;
        en_i = 1'b1; req_i = 4'b1111; data_i = 32'h44_33_22_11;
        expect_load(0, 8'h11, c + 1);
        expect_load(1, 8'h22, c + 43);
        expect_load(2, 8'h33, c + 85);
        expect_load(3, 8'h44, c + 127);
        to_cyc(c + 175);

        // Two requesters hold their requests; the grants must alternate 0,2,0,2.
        autodrop = 1'b0;
        c = cyc;
        req_i = 4'b0101; data_i = 32'h00_52_00_50;
        expect_load(0, 8'h50, c + 1);
        expect_load(2, 8'h52, c + 43);
        expect_load(0, 8'h50, c + 85);
        expect_load(2, 8'h52, c + 127);
        to_cyc(c + 130);
        req_i = '0;
        to_cyc(c + 175);

        // Single request. The data is changed after it is latched, and the busy time is measured.
        autodrop = 1'b1;
        c = cyc;
        req_i = 4'b0001; data_i = 32'h0000_004F;
        expect_load(0, 8'h4F, c + 1);
        step();
        data_i[7:0] = 8'hAA;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy_o) n++;
        end
        chk("busy_len", 32'(n), 32'd41);
        step();

        // en_i drops 10 cycles into WAIT. The frame still completes, and no load occurs while en_i is low.
        c = cyc;
        req_i = 4'b0010; data_i = 32'h00_00_61_00;
        expect_load(1, 8'h61, c + 1);
        to_cyc(c + 12);
        en_i = 1'b0;
        req_i[3] = 1'b1; data_i[31:24] = 8'h73;
        to_cyc(c + 60);
        @(negedge clk);
        chk("busy_after_frame_en0", {31'h0, busy_o}, 32'h0);
        chk("gnt_after_frame_en0", {28'h0, gnt_o}, 32'h0);
        step();
        c = cyc;
        en_i = 1'b1;
        expect_load(3, 8'h73, c + 1);
        to_cyc(c + 50);

        // Reset during WAIT forces every output to zero at once, and ptr restarts at requester 0.
        c = cyc;
        req_i = 4'b0010; data_i = 32'h00_00_62_00;
        expect_load(1, 8'h62, c + 1);
        to_cyc(c + 20);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {19'h0, ack_o, gnt_o, load_xmt_o, bus_data_o, busy_o}, 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        c = cyc;
        req_i = 4'b1001; data_i = 32'h83_00_00_80;
        expect_load(0, 8'h80, c + 1);
        expect_load(3, 8'h83, c + 43);
        to_cyc(c + 90);

        // A short req_i[2] pulse during WAIT must not be granted.
        c = cyc;
        req_i = 4'b0001; data_i = 32'h00_92_00_91;
        expect_load(0, 8'h91, c + 1);
        to_cyc(c + 10);
        req_i[2] = 1'b1;
        to_cyc(c + 13);
        req_i[2] = 1'b0;
        to_cyc(c + 100);
        @(negedge clk);
        chk("idle_after_pulse", {31'h0, busy_o}, 32'h0);

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
